ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It is fed by the ID/EX register's a, b and rdn outputs. It accepts one operation at a time and computes it over WordSize cycles. It presents a registered result with its destination register number for the EX/MEM register, and holds busy high so the hazard unit stalls IF/ID/EX while it works.

Parameters:
WordSize, 32, operand/result width; iteration count equals WordSize

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  request; sampled only when state is IDLE
op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  WordSize  rs1 operand / dividend
b  input  WordSize  rs2 operand / divisor
rdn_in  input  5  destination register number
flush  input  1  abort in-flight operation (branch mispredict)
busy  output  1  operation in flight; drives the pipeline stall
done  output  1  one-cycle pulse, result valid
result  output  WordSize  selected product half / quotient / remainder
rdn  output  5  destination register number of result

Behaviour:
- Reset (rstn, asynchronous, active-low): state IDLE; busy=0, done=0, result=0, rdn=0; all internal accumulators 0.
- FSM states: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - start=1 and flush=0 at edge k: latch op and rdn_in.
  - Signed ops: latch absolute values of the operands, plus the result sign. MULH uses sign(a)^sign(b). MULHSU uses sign(a) only. DIV uses sign(a)^sign(b). REM uses sign(a).
  - Clear the iteration counter and go to CALC. busy=1 from the cycle after k.
- CALC: exactly WordSize cycles, counter 0..WordSize-1.
  - Multiply: shift-add into a 2*WordSize product.
  - Divide: restoring, one quotient bit per cycle.
- CALC exit after the last iteration: apply sign correction (two's-complement negate if the sign bit is set), select the result, go to DONE.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DONE: done=1 and result/rdn valid for exactly one cycle; busy=0 in DONE. Return to IDLE. start is not sampled in DONE.
- Latency: start at edge k -> done high in the cycle after edge k+WordSize+1 (33 cycles for WordSize=32). Result and rdn hold their values until the next DONE.
- start while busy=1: ignored, with no queuing.
- flush=1 in any state: next state IDLE, busy=0, done=0 next cycle, result/rdn unchanged. flush overrides start in the same cycle.
- Divide by zero:
  - DIV/DIVU give quotient all ones.
  - REM/REMU give remainder = a, unmodified and unsigned-corrected.
  - Sign correction is bypassed in both cases.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, REM 0.
- Reset asserted mid-operation: immediate return to reset values, with no done pulse.

Optional Feature:
Macro EX_MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, divide-by-zero, signed overflow, and multiply with either operand 0 skip CALC and go directly to DONE. done is high in the cycle after edge k+1 (2-cycle latency) with the values above.
- Undefined: every operation takes the full WordSize-iteration latency. Special-case values are still produced at CALC exit.

Decomposition:
- Shared core package holds:
  - muldiv_op_e enum (3-bit, funct3 values above);
  - muldiv_state_e enum (IDLE, CALC, DONE);
  - constant DIV_OVF_DIVIDEND = 32'h80000000.
- A single module is sufficient. No sub-module: the datapath is one shared shift register plus an adder/subtractor.

Test Plan:
- MUL a=7 b=6 rdn_in=5 -> done 33 cycles after start, result=42, rdn=5; busy high for cycles 1..32.
- MULH a=0x80000000 b=0x80000000 -> result=0x40000000. MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV -100/7 -> 0xFFFFFFF2 (-14); REM -100/7 -> 0xFFFFFFFE (-2).
- DIV a=123 b=0 -> 0xFFFFFFFF; REM a=-5 b=0 -> 0xFFFFFFFB; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. With EX_MULDIV_EARLY_OUT_EN these complete in 2 cycles, otherwise in 33.
- Start DIVU, flush at cycle 10 -> busy=0 next cycle, no done pulse, result unchanged. A new MUL 3*3 is then accepted and done gives 9.
- start re-asserted while busy with different operands -> ignored; the original result is returned. rstn pulsed at cycle 20 -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the execute-stage RV32M multiply/divide unit.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle (EX_MULDIV_EARLY_OUT_EN: zero/overflow early-out).
// Latency: done pulses WordSize+1 cycles after start; 2 cycles for zero/overflow cases with EX_MULDIV_EARLY_OUT_EN.
// Backpressure: busy stalls IF/ID/EX; start is ignored unless idle; flush aborts with no done pulse.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [4:0]          rdn_in,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [WordSize-1:0] result,
  output logic [4:0]          rdn
);

  localparam int              CntW    = $clog2(WordSize);
  localparam logic [CntW-1:0] LastCnt = CntW'(WordSize - 1);

  muldiv_state_e         state_q, state_d;
  muldiv_op_e            op_q, op_in;
  logic [CntW-1:0]       cnt_q;
  logic [4:0]            rdn_q;
  logic                  neg_q;
  logic [WordSize-1:0]   hi_q, lo_q, b_q;

  logic                  accept, last, is_div;
  logic [WordSize-1:0]   abs_a, abs_b, ld_a, ld_b;
  logic                  ld_neg;
  logic [WordSize:0]     add_a, add_b;
  logic [WordSize+1:0]   add_sum;
  logic [WordSize-1:0]   hi_nx, lo_nx;
  logic [2*WordSize-1:0] prod_fin;
  logic [WordSize-1:0]   quo_fin, rem_fin, res_calc;

  assign op_in  = muldiv_op_e'(op);
  assign accept = (state_q == IDLE) && start && !flush;
  assign last   = (cnt_q == LastCnt);
  assign is_div = op_q inside {DIV, DIVU, REM, REMU};
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);

  // Divide-by-zero keeps the raw dividend and no sign: the restoring loop
  // then naturally yields quotient all-ones and remainder equal to a.
  always_comb begin
    abs_a  = a[WordSize-1] ? -a : a;
    abs_b  = b[WordSize-1] ? -b : b;
    ld_a   = a;
    ld_b   = b;
    ld_neg = 1'b0;
    case (op_in)
      MULH: begin
        ld_a   = abs_a;
        ld_b   = abs_b;
        ld_neg = a[WordSize-1] ^ b[WordSize-1];
      end
      MULHSU: begin
        ld_a   = abs_a;
        ld_neg = a[WordSize-1];
      end
      DIV: if (b != '0) begin
        ld_a   = abs_a;
        ld_b   = abs_b;
        ld_neg = a[WordSize-1] ^ b[WordSize-1];
      end
      REM: if (b != '0) begin
        ld_a   = abs_a;
        ld_b   = abs_b;
        ld_neg = a[WordSize-1];
      end
      default: ;
    endcase
  end

  // One shared adder: hi + b for multiply, {rem,next bit} - b for divide.
  always_comb begin
    add_a   = is_div ? {hi_q, lo_q[WordSize-1]} : {1'b0, hi_q};
    add_b   = is_div ? ~{1'b0, b_q} : {1'b0, b_q};
    add_sum = {1'b0, add_a} + {1'b0, add_b} + (WordSize+2)'(is_div);
    if (is_div) begin
      hi_nx = add_sum[WordSize+1] ? add_sum[WordSize-1:0] : {hi_q[WordSize-2:0], lo_q[WordSize-1]};
      lo_nx = {lo_q[WordSize-2:0], add_sum[WordSize+1]};
    end else if (lo_q[0]) begin
      hi_nx = add_sum[WordSize:1];
      lo_nx = {add_sum[0], lo_q[WordSize-1:1]};
    end else begin
      hi_nx = {1'b0, hi_q[WordSize-1:1]};
      lo_nx = {hi_q[0], lo_q[WordSize-1:1]};
    end
  end

  always_comb begin
    prod_fin = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    quo_fin  = neg_q ? -lo_nx : lo_nx;
    rem_fin  = neg_q ? -hi_nx : hi_nx;
    case (op_q)
      MUL:                 res_calc = prod_fin[WordSize-1:0];
      MULH, MULHSU, MULHU: res_calc = prod_fin[2*WordSize-1:WordSize];
      DIV, DIVU:           res_calc = quo_fin;
      default:             res_calc = rem_fin;
    endcase
  end

`ifdef EX_MULDIV_EARLY_OUT_EN
  localparam logic [WordSize-1:0] MinNeg = {1'b1, {(WordSize-1){1'b0}}};

  logic                early_hit;
  logic [WordSize-1:0] early_res;

  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if ((op_in inside {DIV, DIVU, REM, REMU}) && b == '0) begin
      early_hit = 1'b1;
      early_res = (op_in inside {DIV, DIVU}) ? {WordSize{1'b1}} : a;
    end else if ((op_in == DIV || op_in == REM) && a == MinNeg && b == {WordSize{1'b1}}) begin
      early_hit = 1'b1;
      early_res = (op_in == DIV) ? MinNeg : '0;
    end else if (!(op_in inside {DIV, DIVU, REM, REMU}) && (a == '0 || b == '0)) begin
      early_hit = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
`ifdef EX_MULDIV_EARLY_OUT_EN
        state_d = early_hit ? DONE : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q   <= MUL;
      cnt_q  <= '0;
      rdn_q  <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      result <= '0;
      rdn    <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      rdn_q <= rdn_in;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= ld_a;
      b_q   <= ld_b;
      neg_q <= ld_neg;
`ifdef EX_MULDIV_EARLY_OUT_EN
      if (early_hit) begin
        result <= early_res;
        rdn    <= rdn_in;
      end
`endif
    end else if (state_q == CALC && !flush) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q + CntW'(1);
      if (last) begin
        result <= res_calc;
        rdn    <= rdn_q;
      end
    end
  end

endmodule
